// File: rtl/dmem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : dmem_arbiter
// Description : Round-robin arbiter/sequencer for two requesters (CPU port A,
//               debug/DMA port B) sharing a combinational-read,
//               synchronous-write data memory. Each won request is latched and
//               drives the memory for exactly one ACCESS cycle. Load data is
//               returned registered, with a one-cycle valid pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_arbiter #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 8
) (
    input  logic              clk,
    input  logic              rst,

    // Port A: CPU load/store stage
    input  logic              req_a,
    input  logic              we_a,
    input  logic [ADDR_W-1:0] addr_a,
    input  logic [DATA_W-1:0] wdata_a,
    output logic              gnt_a,
    output logic              rvalid_a,
    output logic [DATA_W-1:0] rdata_a,

    // Port B: debug/DMA loader
    input  logic              req_b,
    input  logic              we_b,
    input  logic [ADDR_W-1:0] addr_b,
    input  logic [DATA_W-1:0] wdata_b,
    output logic              gnt_b,
    output logic              rvalid_b,
    output logic [DATA_W-1:0] rdata_b,

    // Memory side
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    input  logic [DATA_W-1:0] mem_rdata,

    output logic              busy
);

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_ACCESS = 1'b1
    } state_t;

    localparam logic C_PORT_A = 1'b0;
    localparam logic C_PORT_B = 1'b1;

    state_t              r_state;
    logic                r_last;    // port that won most recently
    logic                r_owner;   // port owning the current ACCESS
    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_wdata;

    logic                w_elig_a;
    logic                w_elig_b;
    logic                w_win_valid;
    logic                w_win;

    // Eligibility and winner selection; the owner's request is still high
    // during its own ACCESS cycle and must not win again.
    always_comb begin
        w_elig_a    = req_a & ~((r_state == S_ACCESS) && (r_owner == C_PORT_A));
        w_elig_b    = req_b & ~((r_state == S_ACCESS) && (r_owner == C_PORT_B));
        w_win_valid = w_elig_a | w_elig_b;
        if (w_elig_a && w_elig_b) begin
            w_win = ~r_last;
        end else begin
            w_win = w_elig_b ? C_PORT_B : C_PORT_A;
        end
    end

    // FSM: arbitration, command latch, grant/busy and read-data return.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_last   <= C_PORT_B;
            r_owner  <= C_PORT_A;
            r_we     <= 1'b0;
            r_addr   <= '0;
            r_wdata  <= '0;
            gnt_a    <= 1'b0;
            gnt_b    <= 1'b0;
            rvalid_a <= 1'b0;
            rvalid_b <= 1'b0;
            rdata_a  <= '0;
            rdata_b  <= '0;
            busy     <= 1'b0;
        end else begin
            rvalid_a <= 1'b0;
            rvalid_b <= 1'b0;

            // Load completing at the end of this ACCESS cycle
            if ((r_state == S_ACCESS) && !r_we) begin
                if (r_owner == C_PORT_A) begin
                    rdata_a  <= mem_rdata;
                    rvalid_a <= 1'b1;
                end else begin
                    rdata_b  <= mem_rdata;
                    rvalid_b <= 1'b1;
                end
            end

            if (w_win_valid) begin
                r_state <= S_ACCESS;
                r_last  <= w_win;
                r_owner <= w_win;
                if (w_win == C_PORT_B) begin
                    r_we    <= we_b;
                    r_addr  <= addr_b;
                    r_wdata <= wdata_b;
                end else begin
                    r_we    <= we_a;
                    r_addr  <= addr_a;
                    r_wdata <= wdata_a;
                end
                gnt_a <= (w_win == C_PORT_A);
                gnt_b <= (w_win == C_PORT_B);
                busy  <= 1'b1;
            end else begin
                r_state <= S_IDLE;
                gnt_a   <= 1'b0;
                gnt_b   <= 1'b0;
                busy    <= 1'b0;
            end
        end
    end

    // Memory drive: address/data hold the last latched command when idle;
    // the write strobe is killed by reset even in the middle of an ACCESS.
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;
    assign mem_we    = r_we & (r_state == S_ACCESS) & ~rst;

endmodule
`default_nettype wire
